prim_fifo_n: RTL and testbench
==============================

Name: prim_fifo_n

Overview:
- Parametrised successor to the two-entry skid buffer: a DEPTH-entry synchronous valid/ready FIFO with downstream stall, flush, occupancy count and almost-full flag.
- Sits between pipeline stages (fetch/decode, LSU queues) where more than one outstanding beat must be absorbed without upstream back-pressure.
- Storage is a circular flop array; output is read combinationally from the head entry.

Parameters:
- WIDTH, 32, payload width in bits.
- DEPTH, 4, number of entries; power of two, >= 2.
- AFULL_LVL, DEPTH-1, occupancy at or above which afull_o asserts; range 1..DEPTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush_i  input  1  synchronous clear of all entries; same effect as reset, no effect on the current-cycle outputs.
- urdy_o  output  1  upstream ready; high when not full.
- uvld_i  input  1  upstream valid.
- udat_i  input  WIDTH  upstream data.
- dstall_i  input  1  downstream stall; masks dvld_o and blocks pops.
- drdy_i  input  1  downstream ready.
- dvld_o  output  1  downstream valid.
- ddat_o  output  WIDTH  downstream data (head entry).
- count_o  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- afull_o  output  1  count_o >= AFULL_LVL.

Behaviour:
- State: mem[DEPTH], rptr/wptr of $clog2(DEPTH) bits, count of $clog2(DEPTH+1) bits. All pointers wrap naturally at DEPTH.
- Reset (reset=1 at a clock edge): rptr=wptr=count=0. Resulting outputs:
  - urdy_o=1, dvld_o=0, count_o=0, afull_o=0.
  - ddat_o is don't-care; mem contents are not reset.
- Outputs are functions of registered state only, plus dstall_i:
  - urdy_o = (count != DEPTH).
  - dvld_o = (count != 0) & !dstall_i.
  - ddat_o = mem[rptr].
- Handshake:
  - push = uvld_i & urdy_o. Writes udat_i to mem[wptr] and increments wptr.
  - pop = dvld_o & drdy_i. Increments rptr.
  - Only valid beats are stored; idle cycles consume no entry.
- Count update: push & !pop -> +1; pop & !push -> -1; both or neither -> unchanged.
- Latency: a push into an empty FIFO appears on dvld_o/ddat_o in the next cycle. There is no same-cycle bypass.
- Full: urdy_o=0, so no push is possible even if a pop occurs in the same cycle. urdy_o returns high the cycle after a pop.
- Empty: dvld_o=0 regardless of drdy_i. Push and pop on the same cycle is impossible when empty.
- Stall: dstall_i=1 forces dvld_o=0 and blocks pops. Pushes continue until full. ddat_o keeps presenting the head.
- Priority: reset > flush_i > push/pop. A push or pop on a flush cycle is discarded; the FIFO is empty next cycle.
- Reset or flush mid-stream drops all stored beats. Upstream must not expect acceptance of a beat presented on that cycle.
- Data stability: the head entry and dvld_o stay stable while count != 0, dstall_i=0 and drdy_i=0. Upstream udat_i need not be held after the push cycle.

Decomposition:
- No shared package required. Pointer and count widths are derived locally from DEPTH via $clog2.
- Add the helper function to prim_pkg only if prim_pkg already exports one.
- No sub-module: storage is an inline flop array.
- A future SRAM-backed variant would split storage into prim_fifo_mem with an identical pointer interface.

Test Plan (WIDTH=8, DEPTH=4, AFULL_LVL=3):
- Reset, then one push of 0xA5 with drdy_i=0 -> next cycle dvld_o=1, ddat_o=0xA5, count_o=1; pop -> dvld_o=0, count_o=0.
- Push 0x01..0x04 back-to-back with drdy_i=0 -> count_o reaches 3 (afull_o=1), then 4 (urdy_o=0); a 0x05 presented is not accepted. Drain yields 0x01,0x02,0x03,0x04 in order.
- Full FIFO, pop and push (0x05) on the same cycle -> pop accepted, push refused; count_o=3. urdy_o=1 the next cycle, then 0x05 is accepted.
- Steady stream with uvld_i=drdy_i=1 -> one beat per cycle, count_o stays at 1 and never exceeds it; wptr/rptr wrap past 3 without loss over 12 beats.
- Two entries stored, dstall_i=1 with drdy_i=1 for 3 cycles -> dvld_o=0, no pop, count_o=2. Release -> 0x.. head popped first, order preserved.
- Three entries stored, assert flush_i together with uvld_i=1 and drdy_i=1 -> next cycle count_o=0, dvld_o=0, urdy_o=1. The flushed-cycle push never appears on the output; a reset mid-stream gives the same result.

Source files
------------

// File: rtl/prim_fifo_n.sv
// DEPTH-entry valid/ready FIFO: circular flop array with head read combinationally,
// downstream stall masking, synchronous flush, occupancy count and almost-full flag.
module prim_fifo_n #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned AFULL_LVL = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush_i,
   output logic                       urdy_o,
   input  logic                       uvld_i,
   input  logic [WIDTH-1:0]           udat_i,
   input  logic                       dstall_i,
   input  logic                       drdy_i,
   output logic                       dvld_o,
   output logic [WIDTH-1:0]           ddat_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       afull_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_s, pop_s;

   // Outputs depend only on registered state, except the stall mask on dvld_o.
   assign urdy_o  = (count_q != CW'(DEPTH));
   assign dvld_o  = (count_q != CW'(0)) & ~dstall_i;
   assign ddat_o  = mem_q[rptr_q];
   assign count_o = count_q;
   assign afull_o = (count_q >= CW'(AFULL_LVL));

   assign push_s = uvld_i & urdy_o;
   assign pop_s  = dvld_o & drdy_i;

   // Next-state for pointers and occupancy.
   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (push_s) begin
         wptr_d = wptr_q + PW'(1);
      end else begin
         wptr_d = wptr_q;
      end
      if (pop_s) begin
         rptr_d = rptr_q + PW'(1);
      end else begin
         rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer/count state; reset outranks flush, both discard any same-cycle push/pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         rptr_q  <= PW'(0);
         wptr_q  <= PW'(0);
         count_q <= CW'(0);
      end else if (flush_i) begin
         rptr_q  <= PW'(0);
         wptr_q  <= PW'(0);
         count_q <= CW'(0);
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   // Storage is never cleared; only accepted beats are written.
   always_ff @(posedge clk) begin
      if (push_s && !reset && !flush_i) begin
         mem_q[wptr_q] <= udat_i;
      end
   end

endmodule

// File: tb/tb_prim_fifo_n.sv
// Directed, table-driven bench for prim_fifo_n (WIDTH=8, DEPTH=4, AFULL_LVL=3).
module tb_prim_fifo_n;

   logic       clk = 1'b0;
   logic       reset, flush_i, uvld_i, dstall_i, drdy_i;
   logic [7:0] udat_i;
   logic       urdy_o, dvld_o, afull_o;
   logic [7:0] ddat_o;
   logic [2:0] count_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       rst, fl, uv, st, dr;
      logic [7:0] ud;
      logic       chk, chk_dat;
      logic       e_urdy, e_dvld, e_afull;
      logic [7:0] e_ddat;
      logic [2:0] e_cnt;
   } vec_t;

   vec_t vecs [$];

   prim_fifo_n #(.WIDTH(8), .DEPTH(4), .AFULL_LVL(3)) dut (
      .clk(clk), .reset(reset), .flush_i(flush_i),
      .urdy_o(urdy_o), .uvld_i(uvld_i), .udat_i(udat_i),
      .dstall_i(dstall_i), .drdy_i(drdy_i),
      .dvld_o(dvld_o), .ddat_o(ddat_o),
      .count_o(count_o), .afull_o(afull_o)
   );

   always #5 clk = ~clk;

   function automatic vec_t v(logic rst, logic fl, logic uv, logic [7:0] ud, logic st, logic dr,
                              logic chk, logic e_urdy, logic e_dvld, logic chk_dat,
                              logic [7:0] e_ddat, logic [2:0] e_cnt, logic e_afull);
      vec_t r;
      r.rst = rst; r.fl = fl; r.uv = uv; r.ud = ud; r.st = st; r.dr = dr;
      r.chk = chk; r.chk_dat = chk_dat;
      r.e_urdy = e_urdy; r.e_dvld = e_dvld; r.e_ddat = e_ddat;
      r.e_cnt = e_cnt; r.e_afull = e_afull;
      return r;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic rst, logic fl, logic uv, logic [7:0] ud, logic st, logic dr);
      @(negedge clk);
      reset = rst; flush_i = fl; uvld_i = uv; udat_i = ud; dstall_i = st; drdy_i = dr;
      #1;
   endtask

   initial begin
      int max_cnt;
      reset = 1'b1; flush_i = 1'b0; uvld_i = 1'b0; udat_i = 8'h00; dstall_i = 1'b0; drdy_i = 1'b0;

      //        rst   fl    uv    ud     st    dr    chk   urdy  dvld  cdat  ddat   cnt   afull
      vecs.push_back(v(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0));
      // single beat
      vecs.push_back(v(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd1, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd1, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0));
      // fill to full, 0x05 refused
      vecs.push_back(v(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 3'd1, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 3'd2, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 3'd3, 1'b1));
      vecs.push_back(v(1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 3'd4, 1'b1));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 3'd4, 1'b1));
      // full: pop with push on the same cycle, push refused
      vecs.push_back(v(1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 3'd4, 1'b1));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 3'd3, 1'b1));
      vecs.push_back(v(1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 3'd3, 1'b1));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 3'd4, 1'b1));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 3'd3, 1'b1));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 3'd2, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 3'd1, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0));
      // stall with drdy high: no pop, head held
      vecs.push_back(v(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 3'd1, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 3'd2, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 3'd2, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 3'd2, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 3'd2, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 3'd1, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0));
      // flush with push+pop pending, outputs unaffected that cycle
      vecs.push_back(v(1'b0, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b1, 8'h32, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h31, 3'd1, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h31, 3'd2, 1'b0));
      vecs.push_back(v(1'b0, 1'b1, 1'b1, 8'h34, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h31, 3'd3, 1'b1));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0));
      // reset mid-stream
      vecs.push_back(v(1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h41, 3'd1, 1'b0));
      vecs.push_back(v(1'b1, 1'b0, 1'b1, 8'h43, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h41, 3'd2, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0));
      // fresh beat is what comes out, not any discarded one
      vecs.push_back(v(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 3'd1, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 3'd1, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].fl, vecs[i].uv, vecs[i].ud, vecs[i].st, vecs[i].dr);
         if (vecs[i].chk) begin
            check($sformatf("v%0d.urdy", i), {31'd0, urdy_o}, {31'd0, vecs[i].e_urdy});
            check($sformatf("v%0d.dvld", i), {31'd0, dvld_o}, {31'd0, vecs[i].e_dvld});
            check($sformatf("v%0d.count", i), {29'd0, count_o}, {29'd0, vecs[i].e_cnt});
            check($sformatf("v%0d.afull", i), {31'd0, afull_o}, {31'd0, vecs[i].e_afull});
            if (vecs[i].chk_dat) begin
               check($sformatf("v%0d.ddat", i), {24'd0, ddat_o}, {24'd0, vecs[i].e_ddat});
            end
         end
      end

      // steady stream: 12 beats at one per cycle, pointers wrap three times
      max_cnt = 0;
      for (int i = 0; i <= 12; i++) begin
         drive(1'b0, 1'b0, (i < 12), 8'h60 + 8'(i), 1'b0, 1'b1);
         if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
         check($sformatf("stream%0d.count", i), {29'd0, count_o}, (i == 0) ? 32'd0 : 32'd1);
         check($sformatf("stream%0d.dvld", i), {31'd0, dvld_o}, (i == 0) ? 32'd0 : 32'd1);
         if (i > 0) begin
            check($sformatf("stream%0d.ddat", i), {24'd0, ddat_o}, 32'h60 + 32'(i - 1));
         end
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check("stream.empty", {29'd0, count_o}, 32'd0);
      check("stream.maxcnt", 32'(max_cnt), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
